// File: rtl/core_id_reg_file_mp_pkg.sv
// Shared constants, types and helpers for the decode-stage integer register file.
package core_rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int rf_aw(input int nreg);
        return $clog2(nreg);
    endfunction

    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] rf_data_t;

endpackage

// File: rtl/core_id_reg_file_mp_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, issue wins on conflict.
module core_rf_scoreboard
    import core_rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    parameter int AW   = rf_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREG-1:0]   pending,
    output logic              any_pending
);

    logic [NREG-1:0] pending_nxt;

    always_comb begin
        pending_nxt = pending;
        pending_nxt[0] = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            logic clr;
            clr = 1'b0;
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
                    clr = 1'b1;
                end
            end
            // A new producer supersedes the one being written back.
            if (issue_en && (issue_addr == AW'(r))) begin
                pending_nxt[r] = 1'b1;
            end else if (clr) begin
                pending_nxt[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign any_pending = |pending;

endmodule

// File: rtl/core_id_reg_file_mp.sv
// Multi-port decode register file with pending scoreboard.
// Define CORE_REG_FILE_BYPASS_EN to build same-cycle write-to-read forwarding.
module core_id_reg_file_mp
    import core_rf_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = rf_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    output logic                any_pending
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pending;

    // Ascending port order lets the highest-index port's assignment land last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    core_rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .pending     (pending),
        .any_pending (any_pending)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            hit;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            rdat = mem[ra];
            hit  = 1'b0;
`ifdef CORE_REG_FILE_BYPASS_EN
            // Forwarding is gated by reset so in-flight writes are not visible while cleared.
            for (int unsigned w = 0; w < NWR; w++) begin
                if (rst_n && wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                    rdat = wr_data[w*XLEN +: XLEN];
                    hit  = 1'b1;
                end
            end
`endif
            if (ra == '0) begin
                rdat = '0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rdat;
        assign rd_busy[i] = (ra != '0) && pending[ra] && !hit;
    end

endmodule

// File: doc/core_id_reg_file_mp.md
Name: core_id_reg_file_mp

Overview:
Parametrised multi-port integer register file for the decode stage. Adds the following over a 2R1W file:
- configurable width, depth, read-port count and write-port count
- asynchronous clear
- same-cycle write-to-read forwarding
- a per-register pending scoreboard, set when decode issues a producer and cleared on writeback.

It feeds the decode stall logic directly.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 2, number of write (writeback) ports
AW, $clog2(NREG), register address width (derived, localparam)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  port i: source register has an outstanding producer
wr_en  in  NWR  writeback enable per port
wr_addr  in  NWR*AW  packed writeback addresses
wr_data  in  NWR*XLEN  packed writeback data
issue_en  in  1  decode issued an instruction that will write issue_addr
issue_addr  in  AW  destination register of the issued instruction
any_pending  out  1  OR of all pending bits (used by fence/CSR drain)

Behaviour:
Reset and clock:
- One clock (clk); reset rst_n is asynchronous, active-low.
- While rst_n=0: all registers are 0; all pending bits are 0; rd_busy=0; any_pending=0.
- Reset asserted mid-operation discards every in-flight write and issue immediately.
- Register 0 is hardwired:
  - reads return 0
  - writes are ignored
  - issue to address 0 is ignored (never pending).

Writes:
- Registered at the rising clk edge; visible in storage from the next cycle.
- Several wr ports targeting the same address in one cycle: the highest port index wins, for both data and the pending clear.

Reads (combinational, zero latency):
- Address 0 returns 0.
- Else, if forwarding is enabled and any wr port has wr_en=1 with a matching address this cycle, the data of the highest matching port is returned.
- Else, the stored value is returned.

Scoreboard (pending[NREG-1:1]), per address at each edge:
- set if issue_en and issue_addr matches
- else clear if any wr_en with a matching address
- else hold.
- Simultaneous issue and writeback to the same address leaves pending=1, because the new producer supersedes the old one.

rd_busy[i]:
- 0 if rd_addr[i]=0.
- Otherwise pending[rd_addr[i]] AND NOT (forwarding enabled AND a same-cycle matching write).
- An issue in the current cycle does not affect rd_busy until the next cycle.

Other rules:
- any_pending is the OR of the registered pending bits; it carries no combinational path from the inputs.
- Index arithmetic: addresses are unsigned AW bits, no wrap beyond NREG.
- The scoreboard does not count producers: a second issue to an already pending register keeps a single bit.

Optional Feature:
Macro: CORE_REG_FILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding and the rd_busy suppression described above are built.
- Undefined: no forwarding paths. A read returns the stored value, and rd_busy stays 1 in the writeback cycle, dropping the cycle after. This saves NRD*NWR comparators and muxes for small FPGA builds.

Decomposition:
Package core_rf_pkg holds:
- constants XLEN_DEF=32 and NREG_DEF=32
- function rf_aw(nreg) returning the address width
- typedef rf_addr_t (logic [4:0]) and rf_data_t (logic [31:0]) for the default configuration.

One sub-module is natural: core_rf_scoreboard (pending bits, set/clear priority, any_pending), instantiated once. The storage array, read muxes and forwarding stay in the top.

Test Plan:
1. Reset: hold rst_n=0 with wr_en=2'b11 and random data -> all rd_data=0, rd_busy=0, any_pending=0; release, read r1..r31 -> all 0.
2. Basic write/read: write r5=32'hDEADBEEF on port 0 -> with BYPASS_EN, rd_data same cycle = DEADBEEF; without it, the old value (0) then DEADBEEF next cycle.
3. Write conflict: port 0 writes r7=32'h1111, port 1 writes r7=32'h2222 in the same cycle -> r7=32'h2222 afterwards.
4. Register zero: write r0=32'hFFFFFFFF and issue r0 -> rd_data for r0 = 0, rd_busy=0, any_pending stays 0.
5. Scoreboard: issue r3 at cycle N -> rd_busy(r3)=1 from N+1. Writeback r3 at N+4 -> rd_busy=0 in N+4 (BYPASS_EN) or N+5 (no macro). Issue and writeback r3 in the same cycle -> remains busy.
6. Async reset mid-flight: pending r3, r9 set, assert rst_n=0 between edges -> any_pending and rd_busy drop to 0 immediately, without a clock edge.
